// File: rtl/stream_mux_arb.sv
// N-channel registered stream multiplexer with fixed-select or round-robin grant.
// Optional packet lock is enabled by defining STREAM_MUX_PKT_LOCK_EN.
module stream_mux_arb #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_last;
  logic [SELW-1:0]  r_chan;
  logic [SELW-1:0]  r_ptr;

  logic             w_load;
  logic             w_gv;
  logic [SELW-1:0]  w_g;
  logic             w_fix_gv;
  logic [SELW-1:0]  w_fix_g;
  logic             w_rr_gv;
  logic [SELW-1:0]  w_rr_g;
  logic [WIDTH-1:0] w_gdata;
  logic             w_glast;
  logic [SELW-1:0]  w_ptr_nxt;
  logic [N-1:0]     w_ready;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             r_lock;
  logic [SELW-1:0]  r_lock_ch;
`endif

  // Channel index base+off reduced modulo N without a divider.
  function automatic logic [SELW-1:0] rr_idx(input logic [SELW-1:0] base, input int off);
    logic [SELW:0] s;
    s = {1'b0, base} + (SELW+1)'(off);
    if (s >= (SELW+1)'(N)) s = s - (SELW+1)'(N);
    return s[SELW-1:0];
  endfunction

  always_comb begin
    w_fix_g  = sel;
    w_fix_gv = 1'b0;
    if ({1'b0, sel} < (SELW+1)'(N)) w_fix_gv = in_valid[sel];
  end

  // Walk offsets from the far end so the nearest valid channel after ptr wins.
  always_comb begin
    w_rr_g  = r_ptr;
    w_rr_gv = |in_valid;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[rr_idx(r_ptr, k)]) w_rr_g = rr_idx(r_ptr, k);
    end
  end

  always_comb begin
    w_g  = mode ? w_rr_g  : w_fix_g;
    w_gv = mode ? w_rr_gv : w_fix_gv;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (r_lock) begin
      w_g  = r_lock_ch;
      w_gv = in_valid[r_lock_ch];
    end
`endif
  end

  assign w_load    = !r_valid || out_ready;
  assign w_gdata   = in_data[int'(w_g)*WIDTH +: WIDTH];
  assign w_glast   = in_last[w_g];
  assign w_ptr_nxt = (w_g == SELW'(N - 1)) ? '0 : w_g + 1'b1;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N; i++) begin
      w_ready[i] = !rst && w_load && w_gv && (w_g == SELW'(i));
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_gv) begin
        r_data  <= w_gdata;
        r_valid <= 1'b1;
        r_last  <= w_glast;
        r_chan  <= w_g;
        r_ptr   <= w_ptr_nxt;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_load && w_gv) begin
      if (w_glast) begin
        r_lock <= 1'b0;
      end else begin
        r_lock    <= 1'b1;
        r_lock_ch <= w_g;
      end
    end
  end
`endif

  assign in_ready  = w_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Scoreboard bench for stream_mux_arb: per-channel sources, a reference grant model
// and directed sequences; expectations follow STREAM_MUX_PKT_LOCK_EN when defined.
`timescale 1ns/1ps
module tb_stream_mux_arb;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;
  localparam int DEPTH = 512;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_last;
  logic [SELW-1:0]    out_chan;
  logic               out_ready;

  always #5 clk = ~clk;

  stream_mux_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_chan(out_chan), .out_ready(out_ready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [WIDTH:0] src_mem [N][DEPTH];
  int             src_wr [N];
  int             src_rd [N];

  task automatic push_src(input int ch, input logic [WIDTH-1:0] d, input logic l);
    if (src_wr[ch] < DEPTH) begin
      src_mem[ch][src_wr[ch]] = {l, d};
      src_wr[ch]++;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_wr[i] - src_rd[i];
    return s;
  endfunction

  logic [SELW-1:0]       m_ptr, m_lock_ch, m_g;
  logic                  m_lock, m_ovalid, m_gv, m_load;
  logic [WIDTH+SELW:0]   sb_q[$];
  int                    chan_log[$];
  int                    exp_seq[5];
  logic [N-1:0]          acc;

  task automatic model_grant();
    m_gv = 1'b0;
    m_g  = '0;
    if (mode == 1'b0) begin
      m_g  = sel;
      m_gv = in_valid[sel];
    end else begin
      for (int off = 0; off < N; off++) begin
        int c;
        c = (int'(m_ptr) + off) % N;
        if (!m_gv && in_valid[c]) begin
          m_g  = SELW'(c);
          m_gv = 1'b1;
        end
      end
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (m_lock) begin
      m_g  = m_lock_ch;
      m_gv = in_valid[m_lock_ch];
    end
`endif
    m_load = !m_ovalid || out_ready;
  endtask

  task automatic drive_and_check();
    logic [N-1:0]        exp_ready;
    logic [WIDTH+SELW:0] e;
    for (int i = 0; i < N; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        in_valid[i] = 1'b1;
        in_data[i*WIDTH +: WIDTH] = src_mem[i][src_rd[i]][WIDTH-1:0];
        in_last[i] = src_mem[i][src_rd[i]][WIDTH];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*WIDTH +: WIDTH] = '0;
        in_last[i] = 1'b0;
      end
    end
    #1;
    model_grant();
    exp_ready = (!rst && m_load && m_gv) ? (N'(1) << m_g) : '0;
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    check_eq("out_valid", 32'(out_valid), 32'(m_ovalid));
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_count", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check_eq("out_data", 32'(out_data), 32'(e[WIDTH-1:0]));
        check_eq("out_last", 32'(out_last), 32'(e[WIDTH]));
        check_eq("out_chan", 32'(out_chan), 32'(e[WIDTH+SELW:WIDTH+1]));
        chan_log.push_back(int'(out_chan));
      end
    end
  endtask

  task automatic clock_edge();
    acc = in_ready & in_valid;
    @(posedge clk);
    if (rst) begin
      m_ovalid = 1'b0;
      m_ptr    = '0;
      m_lock   = 1'b0;
      sb_q.delete();
    end else if (m_load) begin
      if (m_gv) begin
        sb_q.push_back({m_g, in_last[m_g], in_data[int'(m_g)*WIDTH +: WIDTH]});
        m_ovalid = 1'b1;
        m_ptr    = (m_g == SELW'(N - 1)) ? '0 : m_g + 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (in_last[m_g]) begin
          m_lock = 1'b0;
        end else begin
          m_lock    = 1'b1;
          m_lock_ch = m_g;
        end
`endif
      end else begin
        m_ovalid = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) if (acc[i]) src_rd[i]++;
    @(negedge clk);
  endtask

  task automatic cycle();
    drive_and_check();
    clock_edge();
  endtask

  task automatic do_reset();
    clear_src();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    while ((pending() > 0 || sb_q.size() > 0 || m_ovalid) && k < max_cyc) begin
      cycle();
      k++;
    end
    check_eq("drain_left", pending() + sb_q.size(), 0);
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, (chan_log.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < chan_log.size()) check_eq(tag, chan_log[i], exp_seq[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] held;
    rst = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0;
    m_ptr = '0; m_lock_ch = '0; m_g = '0; m_lock = 1'b0; m_ovalid = 1'b0;
    m_gv = 1'b0; m_load = 1'b1;
    clear_src();
    @(negedge clk);
    cycle();
    cycle();
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_out_chan", 32'(out_chan), 0);
    check_eq("rst_out_last", 32'(out_last), 0);
    rst = 1'b0;

    // fixed select on channel 2
    mode = 1'b0; sel = 2'd2;
    push_src(2, 8'hA5, 1'b1);
    drive_and_check();
    check_eq("fix_ready", 32'(in_ready), 32'h4);
    clock_edge();
    check_eq("fix_valid", 32'(out_valid), 1);
    check_eq("fix_data", 32'(out_data), 32'hA5);
    check_eq("fix_chan", 32'(out_chan), 2);
    drain(20);

    // round-robin, all channels valid
    do_reset();
    mode = 1'b1;
    for (int b = 0; b < 5; b++)
      for (int ch = 0; ch < N; ch++) push_src(ch, 8'(8'h80 + ch * 16 + b), 1'b1);
    chan_log.delete();
    repeat (6) cycle();
    check_eq("rr_nobubble", chan_log.size(), 5);
    exp_seq = '{0, 1, 2, 3, 0};
    check_log("rr_seq");

    // backpressure while holding a beat
    out_ready = 1'b0;
    held = out_data;
    repeat (3) begin
      drive_and_check();
      check_eq("bp_ready", 32'(in_ready), 0);
      check_eq("bp_hold", 32'(out_data), 32'(held));
      clock_edge();
    end
    out_ready = 1'b1;
    drive_and_check();
    check_eq("bp_release", (in_ready != '0) ? 32'd1 : 32'd0, 1);
    clock_edge();
    drain(100);

    // round-robin skip from ptr=1 with channels 0 and 3
    do_reset();
    chan_log.delete();
    mode = 1'b0; sel = 2'd0;
    push_src(0, 8'h10, 1'b1);
    cycle();
    mode = 1'b1;
    push_src(0, 8'h11, 1'b1); push_src(0, 8'h12, 1'b1);
    push_src(3, 8'h31, 1'b1); push_src(3, 8'h32, 1'b1);
    drain(50);
    exp_seq = '{0, 3, 0, 3, 0};
    check_log("skip_seq");

    // reset while a beat is registered
    do_reset();
    mode = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int ch = 0; ch < N; ch++) push_src(ch, 8'(8'hC0 + ch * 4 + b), 1'b1);
    cycle();
    cycle();
    check_eq("mr_valid_pre", 32'(out_valid), 1);
    rst = 1'b1;
    drive_and_check();
    check_eq("mr_ready", 32'(in_ready), 0);
    clock_edge();
    rst = 1'b0;
    check_eq("mr_valid", 32'(out_valid), 0);
    check_eq("mr_data", 32'(out_data), 0);
    check_eq("mr_chan", 32'(out_chan), 0);
    clear_src();
    push_src(1, 8'h41, 1'b1);
    push_src(2, 8'h42, 1'b1);
    drive_and_check();
    check_eq("mr_first", 32'(in_ready), 32'h2);
    clock_edge();
    drain(20);

    // 3-beat packet on channel 1 against an always-valid channel 0
    do_reset();
    chan_log.delete();
    mode = 1'b0; sel = 2'd0;
    push_src(0, 8'h50, 1'b1);
    cycle();
    mode = 1'b1;
    for (int b = 0; b < 8; b++) push_src(0, 8'(8'h60 + b), 1'b1);
    push_src(1, 8'hB1, 1'b0);
    push_src(1, 8'hB2, 1'b0);
    push_src(1, 8'hB3, 1'b1);
    drain(60);
`ifdef STREAM_MUX_PKT_LOCK_EN
    exp_seq = '{0, 1, 1, 1, 0};
`else
    exp_seq = '{0, 1, 0, 1, 0};
`endif
    check_log("pkt_seq");

    // random traffic, modes and backpressure
    do_reset();
    repeat (400) begin
      if ($urandom_range(0, 1) == 0)
        push_src($urandom_range(0, N - 1), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
      sel = SELW'($urandom_range(0, N - 1));
      cycle();
    end
    mode = 1'b1;
    out_ready = 1'b1;
    for (int ch = 0; ch < N; ch++) push_src(ch, 8'hEE, 1'b1);
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
